// File: rtl/bus_memory_pkg.sv
// Shared types and constants for the bus_memory responder.
package bus_memory_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic        RW_READ   = 1'b1;
    localparam logic        RW_WRITE  = 1'b0;
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_memory_if.sv
// CPU-side address/data/rw bus seen by bus_memory.
interface bus_memory_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       address;
    logic [DATA_W-1:0] datai;
    logic              rw;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              fault;

    modport master (output address, datai, rw, input data, busy, fault);
    modport slave  (input address, datai, rw, output data, busy, fault);
endinterface

// File: rtl/bus_memory_mem_array.sv
// Simple dual-port RAM: one synchronous write port, one enabled synchronous read port, no reset.
module mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);
    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/bus_memory.sv
// Word-addressed bus memory: clear-on-reset sequencer, posted one-entry write buffer with forwarding.
// Optional BUS_MEMORY_MMIO_EN adds an mmio_out register mapped at MMIO_ADDR.
module bus_memory
    import bus_memory_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    bus_memory_if.slave       bus
`ifdef BUS_MEMORY_MMIO_EN
    ,
    output logic [DATA_W-1:0] mmio_out
`endif
);
    state_e                r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_clr_cnt;
    logic                  r_buf_vld;
    logic [DEPTH_LOG2-1:0] r_buf_addr;
    logic [DATA_W-1:0]     r_buf_data;
    logic                  r_fault;
    logic                  r_sel_ram;
    logic [DATA_W-1:0]     r_hold;

    logic                  w_run, w_is_read, w_in_range, w_is_mmio, w_hit, w_commit, w_rd_en;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_waddr;
    logic [DATA_W-1:0]     w_ram_wdata, w_ram_q, w_mmio_word;

    assign w_run      = (r_state == RUN);
    assign w_is_read  = (bus.rw == RW_READ);
    assign w_in_range = (bus.address[31:DEPTH_LOG2] == '0);
    assign w_addr     = bus.address[DEPTH_LOG2-1:0];
    assign w_hit      = r_buf_vld && w_in_range && (r_buf_addr == w_addr);

`ifdef BUS_MEMORY_MMIO_EN
    logic [DATA_W-1:0] r_mmio;
    assign w_is_mmio   = (bus.address == MMIO_ADDR);
    assign w_mmio_word = r_mmio;
    assign mmio_out    = r_mmio;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                          r_mmio <= '0;
        else if (w_run && bus.rw == RW_WRITE && w_is_mmio)   r_mmio <= bus.datai;
    end
`else
    assign w_is_mmio   = 1'b0;
    assign w_mmio_word = '0;
`endif

    // Buffer retires on any in-range write to a new address, or on a read that cannot use it.
    assign w_commit = w_run && r_buf_vld && !w_hit && (w_is_read || w_in_range);
    assign w_rd_en  = w_run && w_is_read && w_in_range && !w_hit;

    assign w_ram_we    = !w_run || w_commit;
    assign w_ram_waddr = w_run ? r_buf_addr : r_clr_cnt;
    assign w_ram_wdata = w_run ? r_buf_data : '0;

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_mem (
        .clock   (clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_addr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_clr_cnt == {DEPTH_LOG2{1'b1}}) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clr_cnt  <= '0;
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_sel_ram  <= 1'b0;
            r_hold     <= '0;
            r_fault    <= 1'b0;
        end else if (!w_run) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end else begin
            if (!w_in_range && !w_is_mmio) r_fault <= 1'b1;
            if (w_is_read) begin
                // Non-RAM read results are captured in r_hold so data stays put on later writes.
                r_sel_ram <= w_in_range && !w_hit;
                if (w_hit)           r_hold <= r_buf_data;
                else if (w_is_mmio)  r_hold <= w_mmio_word;
                else if (!w_in_range) r_hold <= '0;
                if (w_commit) r_buf_vld <= 1'b0;
            end else if (w_in_range) begin
                r_buf_vld  <= 1'b1;
                r_buf_addr <= w_addr;
                r_buf_data <= bus.datai;
            end
        end
    end

    assign bus.data  = r_sel_ram ? w_ram_q : r_hold;
    assign bus.busy  = !w_run;
    assign bus.fault = r_fault;
endmodule
